// File: rtl/mips_instr_encoder_pkg.sv
// Shared op enum, MIPS opcode/funct constants, encoder state encoding and word builders.
// Decoder and encoder both import this so field layouts stay in one place.
package mips_instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ADDU    = 4'd1,
    OP_SUBU    = 4'd2,
    OP_SLL     = 4'd3,
    OP_JR      = 4'd4,
    OP_SYSCALL = 4'd5,
    OP_ADDIU   = 4'd6,
    OP_ORI     = 4'd7,
    OP_LW      = 4'd8,
    OP_SW      = 4'd9,
    OP_BEQ     = 4'd10,
    OP_LUI     = 4'd11,
    OP_JAL     = 4'd12,
    OP_J       = 4'd13,
    OP_LI      = 4'd14,
    OP_MOVE    = 4'd15
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL      = 6'b000000;
  localparam logic [5:0] FN_JR       = 6'b001000;
  localparam logic [5:0] FN_SYSCALL  = 6'b001100;
  localparam logic [5:0] FN_ADDU     = 6'b100001;
  localparam logic [5:0] FN_SUBU     = 6'b100011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] index);
    return {opc, index};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// Combinational descriptor-to-word mapping; pseudo-ops expand to one or two words.
// Operand range flagging exists only with MIPS_INSTR_ENC_RANGE_CHECK_EN, otherwise range_err is 0.
module mips_instr_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_word,
  output logic        range_err
);

  always_comb begin
    word0    = '0;
    word1    = '0;
    two_word = 1'b0;
    case (op_e'(op))
      OP_NOP:     word0 = '0;
      OP_ADDU:    word0 = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      OP_SUBU:    word0 = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      OP_SLL:     word0 = r_word(5'd0, rt, rd, shamt, FN_SLL);
      OP_JR:      word0 = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_SYSCALL: word0 = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
      OP_ADDIU:   word0 = i_word(OPC_ADDIU, rs, rt, imm[15:0]);
      OP_ORI:     word0 = i_word(OPC_ORI, rs, rt, imm[15:0]);
      OP_LW:      word0 = i_word(OPC_LW, rs, rt, imm[15:0]);
      OP_SW:      word0 = i_word(OPC_SW, rs, rt, imm[15:0]);
      OP_BEQ:     word0 = i_word(OPC_BEQ, rs, rt, imm[15:0]);
      OP_LUI:     word0 = i_word(OPC_LUI, 5'd0, rt, imm[15:0]);
      OP_JAL:     word0 = j_word(OPC_JAL, imm[25:0]);
      OP_J:       word0 = j_word(OPC_J, imm[25:0]);
      OP_LI: begin
        // Small constants fit a single ORI from $0; otherwise build the upper half first.
        if (imm[31:16] == 16'd0) begin
          word0 = i_word(OPC_ORI, 5'd0, rt, imm[15:0]);
        end else begin
          word0    = i_word(OPC_LUI, 5'd0, rt, imm[31:16]);
          word1    = i_word(OPC_ORI, rt, rt, imm[15:0]);
          two_word = 1'b1;
        end
      end
      OP_MOVE:    word0 = r_word(rs, 5'd0, rd, 5'd0, FN_ADDU);
      default:    word0 = '0;
    endcase
  end

`ifdef MIPS_INSTR_ENC_RANGE_CHECK_EN
  logic simm_bad;
  assign simm_bad = (imm[31:16] != {16{imm[15]}});

  always_comb begin
    range_err = 1'b0;
    case (op_e'(op))
      OP_ADDIU, OP_LW, OP_SW, OP_BEQ: range_err = simm_bad;
      OP_ORI, OP_LUI:                 range_err = (imm[31:16] != 16'd0);
      OP_JAL, OP_J:                   range_err = (imm[31:26] != 6'd0);
      default:                        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes op descriptors into MIPS words with one-cycle latency; LI may take two output beats.
// Input stalls while a word is held and unaccepted; MIPS_INSTR_ENC_RANGE_CHECK_EN enables err.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_shamt,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_last,
  output logic               err,
  output logic [COUNT_W-1:0] instr_count
);

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         pend_q, pend_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic [31:0] word0, word1;
  logic        two_word, range_err;
  logic        accept, out_fire;

  mips_instr_pack u_pack (
    .op        (in_op),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .imm       (in_imm),
    .word0     (word0),
    .word1     (word1),
    .two_word  (two_word),
    .range_err (range_err)
  );

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_fire  = out_valid && out_ready;

  assign out_instr   = instr_q;
  assign out_last    = last_q;
  assign err         = err_q;
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pend_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    last_d  = last_q;
    err_d   = 1'b0;
    count_d = count_q + (out_fire ? COUNT_W'(1) : COUNT_W'(0));

    case (state_q)
      ST_EMPTY, ST_ONE: begin
        if (accept) begin
          instr_d = word0;
          pend_d  = word1;
          err_d   = range_err;
          if (two_word) begin
            state_d = ST_PEND;
            last_d  = 1'b0;
          end else begin
            state_d = ST_ONE;
            last_d  = 1'b1;
          end
        end else if ((state_q == ST_ONE) && out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_PEND: begin
        if (out_ready) begin
          instr_d = pend_q;
          last_d  = 1'b1;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed scenarios plus randomized traffic scored against an arithmetic reference model.
module tb_mips_instr_encoder;

  localparam int COUNT_W = 16;
`ifdef MIPS_INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_op;
  logic [4:0]         in_rs, in_rt, in_rd, in_shamt;
  logic [31:0]        in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic               out_last;
  logic               err;
  logic [COUNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_last    (out_last),
    .err         (err),
    .instr_count (instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Reference: field placement by arithmetic on plain integers, straight from the MIPS formats.
  function automatic void model(input int unsigned op, input int unsigned rs, input int unsigned rt,
                                input int unsigned rd, input int unsigned sh, input logic [31:0] imm,
                                output int n, output logic [31:0] w0, output logic [31:0] w1,
                                output bit e);
    int unsigned hi, lo, u;
    bit simm_ok;
    u  = imm;
    hi = u / 65536;
    lo = u % 65536;
    simm_ok = ($signed(imm) >= -32768) && ($signed(imm) <= 32767);
    n = 1; w0 = 0; w1 = 0; e = 0;
    case (op)
      0:  w0 = 0;
      1:  w0 = rs * 2**21 + rt * 2**16 + rd * 2**11 + 33;
      2:  w0 = rs * 2**21 + rt * 2**16 + rd * 2**11 + 35;
      3:  w0 = rt * 2**16 + rd * 2**11 + sh * 64;
      4:  w0 = rs * 2**21 + 8;
      5:  w0 = 12;
      6:  begin w0 = 9  * 2**26 + rs * 2**21 + rt * 2**16 + lo; e = !simm_ok; end
      7:  begin w0 = 13 * 2**26 + rs * 2**21 + rt * 2**16 + lo; e = (hi != 0); end
      8:  begin w0 = 35 * 2**26 + rs * 2**21 + rt * 2**16 + lo; e = !simm_ok; end
      9:  begin w0 = 43 * 2**26 + rs * 2**21 + rt * 2**16 + lo; e = !simm_ok; end
      10: begin w0 = 4  * 2**26 + rs * 2**21 + rt * 2**16 + lo; e = !simm_ok; end
      11: begin w0 = 15 * 2**26 + rt * 2**16 + lo; e = (hi != 0); end
      12: begin w0 = 3 * 2**26 + u % 2**26; e = (u >= 2**26); end
      13: begin w0 = 2 * 2**26 + u % 2**26; e = (u >= 2**26); end
      14: begin
        if (hi == 0) begin
          w0 = 13 * 2**26 + rt * 2**16 + lo;
        end else begin
          n  = 2;
          w0 = 15 * 2**26 + rt * 2**16 + hi;
          w1 = 13 * 2**26 + rt * 2**21 + rt * 2**16 + lo;
        end
      end
      default: w0 = rs * 2**21 + rd * 2**11 + 33;
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addu();
    do_reset();
    set_desc(4'd1, 5'd1, 5'd2, 5'd3, 5'd7, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addu_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addu_valid got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h0022_1821) begin errors++; $display("FAIL addu_instr got %h want 00221821", out_instr); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL addu_last got %b want 1", out_last); end
    tick();
    @(negedge clk);
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL addu_count got %0d want 1", instr_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addu_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_desc(4'd7, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_1234);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", in_ready); end
    tick();
    set_desc(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0C00);
    @(negedge clk);
    checks++; if (out_instr !== 32'h3408_1234 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ori got %h/%b want 34081234/1", out_instr, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_instr !== 32'h0C00_0C00 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_jal got %h/%b want 0c000c00/1", out_instr, out_valid); end
    tick();
    @(negedge clk);
    checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", instr_count); end
  endtask

  task automatic test_li_stall();
    do_reset();
    set_desc(4'd14, 5'd3, 5'd9, 5'd4, 5'd0, 32'h1234_5678);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_instr !== 32'h3C09_1234 || out_last !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL li_lui_hold[%0d] got %h/%b/%b want 3c091234/0/1", i, out_instr, out_last, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_pend_ready[%0d] got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_pend_ready_rdy got %b want 0", in_ready); end
    tick();
    @(negedge clk);
    checks++; if (out_instr !== 32'h3529_5678 || out_last !== 1'b1) begin errors++; $display("FAIL li_ori got %h/%b want 35295678/1", out_instr, out_last); end
    tick();
    @(negedge clk);
    checks++; if (instr_count !== 16'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL li_count got %0d/%b want 2/0", instr_count, out_valid); end
  endtask

  task automatic test_li_short();
    do_reset();
    set_desc(4'd14, 5'd0, 5'd9, 5'd0, 5'd0, 32'h0000_ABCD);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_instr !== 32'h3409_ABCD || out_last !== 1'b1) begin errors++; $display("FAIL li_short got %h/%b want 3409abcd/1", out_instr, out_last); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || instr_count !== 16'd1) begin errors++; $display("FAIL li_short_one got %b/%0d want 0/1", out_valid, instr_count); end
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    set_desc(4'd14, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1234_5678);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL pend_setup got %b/%b want 1/0", out_valid, out_last); end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_desc(4'd0, 5'd5, 5'd6, 5'd7, 5'd8, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || instr_count !== 16'd0 || out_instr !== 32'd0) begin
      errors++; $display("FAIL pend_reset got %b/%0d/%h want 0/0/0", out_valid, instr_count, out_instr); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'd0 || out_last !== 1'b1) begin
      errors++; $display("FAIL pend_nop got %b/%h/%b want 1/0/1", out_valid, out_instr, out_last); end
  endtask

  task automatic test_range_check();
    do_reset();
    set_desc(4'd6, 5'd0, 5'd4, 5'd0, 5'd0, 32'h0001_0000);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_pre got %b want 0", err); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_instr !== 32'h2404_0000) begin errors++; $display("FAIL range_word got %h want 24040000", out_instr); end
    checks++; if (err !== RC) begin errors++; $display("FAIL range_err got %b want %b", err, RC); end
    tick();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_pulse got %b want 0", err); end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] head;
    bit          acc = 1'b0;
    bit          exp_err = 1'b0;
    bit          e;
    int          hs = 0;
    int          n;
    logic [31:0] w0, w1;
    logic [31:0] imm;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 2990) begin
        if (!in_valid || acc) begin
          if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
              0: imm = $urandom;
              1: imm = $urandom_range(0, 65535);
              2: imm = 32'hFFFF_8000 | $urandom_range(0, 32767);
              default: imm = $urandom_range(0, (1 << 26) - 1);
            endcase
            set_desc(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", i, err, exp_err); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() == 0 || (q.size() == 1 && out_ready))) begin
        errors++; $display("FAIL rnd_in_ready[%0d] got %b held %0d", i, in_ready, q.size()); end
      if (out_valid && out_ready && q.size() != 0) begin
        head = q.pop_front();
        hs++;
        checks++; if ({out_last, out_instr} !== head) begin
          errors++; $display("FAIL rnd_word[%0d] got %b/%h want %b/%h", i, out_last, out_instr, head[32], head[31:0]); end
      end
      acc = in_valid && in_ready;
      exp_err = 1'b0;
      if (acc) begin
        model(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, n, w0, w1, e);
        if (n == 2) begin
          q.push_back({1'b0, w0});
          q.push_back({1'b1, w1});
        end else begin
          q.push_back({1'b1, w0});
        end
        exp_err = e && RC;
      end
      tick();
    end
    @(negedge clk);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
    checks++; if (instr_count !== COUNT_W'(hs)) begin errors++; $display("FAIL rnd_count got %0d want %0d", instr_count, hs); end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
    test_reset();
    test_addu();
    test_back_to_back();
    test_li_stall();
    test_li_short();
    test_reset_in_pend();
    test_range_check();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
